// File: rtl/fb_pingpong_scheduler.sv
// Double-buffer frame-store scheduler: writes whole camera frames into one of two
// banks and hands each completed bank to the processing engine via start/done.
module fb_pingpong_scheduler #(
  parameter int  WIDTH       = 320,
  parameter int  HEIGHT      = 240,
  parameter int  PIXEL_WIDTH = 24,
  localparam int FRAME_SIZE  = WIDTH * HEIGHT,
  localparam int AW          = $clog2(FRAME_SIZE)
) (
  input  logic                   clk_w,
  input  logic                   rst_n,
  input  logic                   cap_valid,
  input  logic                   cap_sof,
  input  logic [PIXEL_WIDTH-1:0] cap_data,
  output logic                   cap_ready,
  output logic                   fb_we,
  output logic [AW:0]            fb_addr,
  output logic [PIXEL_WIDTH-1:0] fb_din,
  output logic                   proc_start,
  output logic                   proc_bank,
  input  logic                   proc_done,
  output logic                   proc_busy,
  output logic [15:0]            frames_written,
  output logic [15:0]            frames_dropped,
  output logic                   sync_err
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_BUSY} bank_st_t;
  typedef enum logic [1:0] {W_SYNC, W_FILL, W_DROP} wr_st_t;

  localparam logic [AW-1:0] LAST_OFF = AW'(FRAME_SIZE - 1);

  wr_st_t        wr_st, wr_st_d;
  bank_st_t      bank_st   [2];
  bank_st_t      bank_st_d [2];
  logic          last_bank;
  logic          wr_bank, wr_bank_d;
  logic [AW-1:0] offset, offset_d, wr_off;

  logic xfer, sof_xfer, have_target, target;
  logic wr_fire, start_frame, frame_done, drop, short_frame;
  logic sched_go, sched_bank;

  assign xfer     = cap_valid && cap_ready;
  assign sof_xfer = xfer && cap_sof;

  // Prefer the bank not filled last, so frames alternate between banks.
  assign have_target = (bank_st[~last_bank] == B_FREE) || (bank_st[last_bank] == B_FREE);
  assign target      = (bank_st[~last_bank] == B_FREE) ? ~last_bank : last_bank;

  // With both banks full, the one not filled last holds the older frame.
  assign sched_go   = !proc_busy && ((bank_st[0] == B_FULL) || (bank_st[1] == B_FULL));
  assign sched_bank = ((bank_st[0] == B_FULL) && (bank_st[1] == B_FULL)) ? ~last_bank
                                                                         : (bank_st[1] == B_FULL);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) wr_st <= W_SYNC;
    else        wr_st <= wr_st_d;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    wr_st_d = wr_st;
    case (wr_st)
      W_SYNC, W_DROP: if (sof_xfer) wr_st_d = have_target ? W_FILL : W_DROP;
      W_FILL:         if (xfer && !cap_sof && (offset == LAST_OFF)) wr_st_d = W_SYNC;
      default:        wr_st_d = W_SYNC;
    endcase
  end

  always_comb begin
    wr_fire     = 1'b0;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    drop        = 1'b0;
    short_frame = 1'b0;
    wr_bank_d   = wr_bank;
    offset_d    = offset;
    wr_off      = offset;
    case (wr_st)
      W_SYNC, W_DROP: begin
        if (sof_xfer) begin
          if (have_target) begin
            wr_fire     = 1'b1;
            start_frame = 1'b1;
            wr_bank_d   = target;
            wr_off      = '0;
            offset_d    = AW'(1);
          end else begin
            drop = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (xfer) begin
          wr_fire = 1'b1;
          if (cap_sof) begin
            // Short frame: abandon the partial frame, restart the same bank.
            short_frame = 1'b1;
            wr_off      = '0;
            offset_d    = AW'(1);
          end else if (offset == LAST_OFF) begin
            frame_done = 1'b1;
            offset_d   = '0;
          end else begin
            offset_d = offset + AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Owners never collide: writer touches FREE/FILLING, scheduler FULL, done BUSY.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_d[b] = bank_st[b];
      if (start_frame && (wr_bank_d == 1'(b)))              bank_st_d[b] = B_FILLING;
      if (frame_done && (wr_bank == 1'(b)))                 bank_st_d[b] = B_FULL;
      if (sched_go && (sched_bank == 1'(b)))                bank_st_d[b] = B_BUSY;
      if (proc_done && proc_busy && (proc_bank == 1'(b)))   bank_st_d[b] = B_FREE;
    end
  end

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0]     <= B_FREE;
      bank_st[1]     <= B_FREE;
      last_bank      <= 1'b1;
      wr_bank        <= 1'b0;
      offset         <= '0;
      cap_ready      <= 1'b0;
      fb_we          <= 1'b0;
      fb_addr        <= '0;
      fb_din         <= '0;
      proc_start     <= 1'b0;
      proc_bank      <= 1'b0;
      proc_busy      <= 1'b0;
      frames_written <= '0;
      frames_dropped <= '0;
      sync_err       <= 1'b0;
    end else begin
      bank_st[0] <= bank_st_d[0];
      bank_st[1] <= bank_st_d[1];
      wr_bank    <= wr_bank_d;
      offset     <= offset_d;
      cap_ready  <= 1'b1;
      fb_we      <= wr_fire;
      if (wr_fire) begin
        fb_addr <= {wr_bank_d, wr_off};
        fb_din  <= cap_data;
      end
      if (frame_done) begin
        last_bank      <= wr_bank;
        frames_written <= frames_written + 16'd1;
      end
      if (drop)        frames_dropped <= frames_dropped + 16'd1;
      if (short_frame) sync_err       <= 1'b1;
      proc_start <= sched_go;
      if (sched_go) begin
        proc_bank <= sched_bank;
        proc_busy <= 1'b1;
      end else if (proc_done && proc_busy) begin
        proc_busy <= 1'b0;
      end
    end
  end

endmodule
